// File: rtl/mem_port_arbiter.sv
// Shares one single-ported, variable-latency memory between instruction fetch and
// MEM-stage load/store. Data wins ties; a watchdog aborts hung accesses.
module mem_port_arbiter #(
    parameter int TIMEOUT = 64
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        i_req_i,
    input  logic [31:0] i_addr_i,
    output logic [31:0] i_rdata_o,
    output logic        i_stall_o,
    input  logic        d_req_i,
    input  logic        d_we_i,
    input  logic [31:0] d_addr_i,
    input  logic [31:0] d_wdata_i,
    output logic [31:0] d_rdata_o,
    output logic        d_stall_o,
    output logic        mem_req_o,
    output logic        mem_we_o,
    output logic [31:0] mem_addr_o,
    output logic [31:0] mem_wdata_o,
    input  logic        mem_ack_i,
    input  logic [31:0] mem_rdata_i,
    output logic        err_o
);

    typedef enum logic [2:0] {IDLE, I_BUSY, D_BUSY, I_DONE, D_DONE} state_t;

    state_t      r_state;
    state_t      w_next;
    logic [7:0]  r_cnt;
    logic        r_icancel;
    logic        r_mem_we;
    logic [31:0] r_mem_addr;
    logic [31:0] r_mem_wdata;
    logic [31:0] r_i_rdata;
    logic [31:0] r_d_rdata;
    logic        r_err;

    logic w_busy;
    logic w_tmo;
    logic w_end;
    logic w_icancel;

    assign w_busy    = (r_state == I_BUSY) || (r_state == D_BUSY);
    assign w_tmo     = w_busy && !mem_ack_i && (r_cnt == 8'(TIMEOUT - 1));
    assign w_end     = w_busy && (mem_ack_i || w_tmo);
    // Sticky: once the fetch is flushed, a re-raised request must not get stale data.
    assign w_icancel = r_icancel || !i_req_i;

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE: begin
                if (d_req_i)      w_next = D_BUSY;
                else if (i_req_i) w_next = I_BUSY;
            end
            I_BUSY:  if (w_end) w_next = w_icancel ? IDLE : I_DONE;
            D_BUSY:  if (w_end) w_next = D_DONE;
            I_DONE:  w_next = IDLE;
            D_DONE:  w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state     <= IDLE;
            r_cnt       <= 8'd0;
            r_icancel   <= 1'b0;
            r_mem_we    <= 1'b0;
            r_mem_addr  <= 32'd0;
            r_mem_wdata <= 32'd0;
            r_i_rdata   <= 32'd0;
            r_d_rdata   <= 32'd0;
            r_err       <= 1'b0;
        end else begin
            r_state <= w_next;
            case (r_state)
                IDLE: begin
                    // BUSY is only entered from IDLE, so clearing here clears on entry.
                    r_cnt     <= 8'd0;
                    r_icancel <= 1'b0;
                    if (d_req_i) begin
                        r_mem_we    <= d_we_i;
                        r_mem_addr  <= d_addr_i;
                        r_mem_wdata <= d_wdata_i;
                    end else if (i_req_i) begin
                        r_mem_we    <= 1'b0;
                        r_mem_addr  <= i_addr_i;
                        r_mem_wdata <= 32'd0;
                    end
                end
                I_BUSY: begin
                    r_cnt <= r_cnt + 8'd1;
                    if (!i_req_i) r_icancel <= 1'b1;
                    if (w_end && !w_icancel) r_i_rdata <= mem_ack_i ? mem_rdata_i : 32'd0;
                    if (w_tmo) r_err <= 1'b1;
                end
                D_BUSY: begin
                    r_cnt <= r_cnt + 8'd1;
                    if (w_end) r_d_rdata <= mem_ack_i ? mem_rdata_i : 32'd0;
                    if (w_tmo) r_err <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign mem_req_o   = w_busy;
    assign mem_we_o    = r_mem_we;
    assign mem_addr_o  = r_mem_addr;
    assign mem_wdata_o = r_mem_wdata;
    assign i_rdata_o   = r_i_rdata;
    assign d_rdata_o   = r_d_rdata;
    assign err_o       = r_err;
    assign i_stall_o   = !rst_i && i_req_i && (r_state != I_DONE);
    assign d_stall_o   = !rst_i && d_req_i && (r_state != D_DONE);

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed table-driven bench for mem_port_arbiter (TIMEOUT = 4), plus a hand-written
// back-to-back / combinational-stall sequence.
module tb_mem_port_arbiter;

    logic        clk = 1'b0;
    logic        rst, ireq, dreq, dwe, ack;
    logic [31:0] iaddr, daddr, dwdata, rdata;
    logic [31:0] irdata_o, drdata_o, maddr_o, mwdata_o;
    logic        istall_o, dstall_o, mreq_o, mwe_o, err_o;

    int n_chk  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    mem_port_arbiter #(.TIMEOUT(4)) dut (
        .clk_i(clk), .rst_i(rst),
        .i_req_i(ireq), .i_addr_i(iaddr), .i_rdata_o(irdata_o), .i_stall_o(istall_o),
        .d_req_i(dreq), .d_we_i(dwe), .d_addr_i(daddr), .d_wdata_i(dwdata),
        .d_rdata_o(drdata_o), .d_stall_o(dstall_o),
        .mem_req_o(mreq_o), .mem_we_o(mwe_o), .mem_addr_o(maddr_o), .mem_wdata_o(mwdata_o),
        .mem_ack_i(ack), .mem_rdata_i(rdata), .err_o(err_o)
    );

    typedef struct {
        logic        rst, ireq;
        logic [31:0] iaddr;
        logic        dreq, dwe;
        logic [31:0] daddr, dwdata;
        logic        ack;
        logic [31:0] rdata;
        logic        e_mreq, e_mwe;
        logic [31:0] e_maddr, e_mwdata;
        logic        e_ist, e_dst;
        logic [31:0] e_ird, e_drd;
        logic        e_err;
    } vec_t;

    vec_t tv[$];

    task automatic add(input logic r, input logic ir, input logic [31:0] ia,
                       input logic dr, input logic dw, input logic [31:0] da, input logic [31:0] dd,
                       input logic ak, input logic [31:0] rd,
                       input logic mr, input logic mw, input logic [31:0] ma, input logic [31:0] md,
                       input logic is, input logic ds, input logic [31:0] ird, input logic [31:0] drd,
                       input logic er);
        vec_t v;
        v.rst = r; v.ireq = ir; v.iaddr = ia; v.dreq = dr; v.dwe = dw; v.daddr = da;
        v.dwdata = dd; v.ack = ak; v.rdata = rd;
        v.e_mreq = mr; v.e_mwe = mw; v.e_maddr = ma; v.e_mwdata = md;
        v.e_ist = is; v.e_dst = ds; v.e_ird = ird; v.e_drd = drd; v.e_err = er;
        tv.push_back(v);
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drive(input vec_t v);
        rst = v.rst; ireq = v.ireq; iaddr = v.iaddr; dreq = v.dreq; dwe = v.dwe;
        daddr = v.daddr; dwdata = v.dwdata; ack = v.ack; rdata = v.rdata;
    endtask

    initial begin
        rst = 1'b1; ireq = 1'b0; iaddr = '0; dreq = 1'b0; dwe = 1'b0;
        daddr = '0; dwdata = '0; ack = 1'b0; rdata = '0;

        //   rst ireq iaddr dreq dwe daddr dwdata ack rdata | mreq mwe maddr mwdata ist dst irdata drdata err
        // reset with both requests high: stalls forced low
        add(1,1,0,      1,0,0,0,                0,0,           0,0,0,0,          0,0,0,0,0);
        // fetch, latency 2
        add(0,1,'h40,   0,0,0,0,                0,0,           1,0,'h40,0,       1,0,0,0,0);
        add(0,1,'h40,   0,0,0,0,                0,0,           1,0,'h40,0,       1,0,0,0,0);
        add(0,1,'h40,   0,0,0,0,                1,'h00500093,  0,0,0,0,          0,0,'h00500093,0,0);
        add(0,0,0,      0,0,0,0,                0,0,           0,0,0,0,          0,0,'h00500093,0,0);
        // simultaneous: data first, then fetch
        add(0,1,'h80,   1,0,'h100,0,            0,0,           1,0,'h100,0,      1,1,'h00500093,0,0);
        add(0,1,'h80,   1,0,'h100,0,            1,'hCAFE0001,  0,0,0,0,          1,0,'h00500093,'hCAFE0001,0);
        add(0,1,'h80,   0,0,0,0,                0,0,           0,0,0,0,          1,0,'h00500093,'hCAFE0001,0);
        add(0,1,'h80,   0,0,0,0,                0,0,           1,0,'h80,0,       1,0,'h00500093,'hCAFE0001,0);
        add(0,1,'h80,   0,0,0,0,                1,'h11112222,  0,0,0,0,          0,0,'h11112222,'hCAFE0001,0);
        add(0,0,0,      0,0,0,0,                0,0,           0,0,0,0,          0,0,'h11112222,'hCAFE0001,0);
        // store
        add(0,0,0,      1,1,'h20,'hDEADBEEF,    0,0,           1,1,'h20,'hDEADBEEF, 0,1,'h11112222,'hCAFE0001,0);
        add(0,0,0,      1,1,'h20,'hDEADBEEF,    0,0,           1,1,'h20,'hDEADBEEF, 0,1,'h11112222,'hCAFE0001,0);
        add(0,0,0,      1,1,'h20,'hDEADBEEF,    1,'h55,        0,0,0,0,          0,0,'h11112222,'h55,0);
        add(0,0,0,      0,0,0,0,                0,0,           0,0,0,0,          0,0,'h11112222,'h55,0);
        // fetch cancel
        add(0,1,'h200,  0,0,0,0,                0,0,           1,0,'h200,0,      1,0,'h11112222,'h55,0);
        add(0,0,'h200,  0,0,0,0,                0,0,           1,0,'h200,0,      0,0,'h11112222,'h55,0);
        add(0,0,0,      0,0,0,0,                1,'h12345678,  0,0,0,0,          0,0,'h11112222,'h55,0);
        add(0,0,0,      0,0,0,0,                0,0,           0,0,0,0,          0,0,'h11112222,'h55,0);
        // timeout (TIMEOUT=4): four BUSY cycles, then abort
        add(0,0,0,      1,0,'h300,0,            0,0,           1,0,'h300,0,      0,1,'h11112222,'h55,0);
        add(0,0,0,      1,0,'h300,0,            0,0,           1,0,'h300,0,      0,1,'h11112222,'h55,0);
        add(0,0,0,      1,0,'h300,0,            0,0,           1,0,'h300,0,      0,1,'h11112222,'h55,0);
        add(0,0,0,      1,0,'h300,0,            0,0,           1,0,'h300,0,      0,1,'h11112222,'h55,0);
        add(0,0,0,      1,0,'h300,0,            0,0,           0,0,0,0,          0,0,'h11112222,0,1);
        add(0,0,0,      0,0,0,0,                0,0,           0,0,0,0,          0,0,'h11112222,0,1);
        // err stays sticky through a good load
        add(0,0,0,      1,0,'h10,0,             0,0,           1,0,'h10,0,       0,1,'h11112222,0,1);
        add(0,0,0,      1,0,'h10,0,             1,'hABCD,      0,0,0,0,          0,0,'h11112222,'hABCD,1);
        add(0,0,0,      0,0,0,0,                0,0,           0,0,0,0,          0,0,'h11112222,'hABCD,1);
        // reset in D_BUSY, then a stale ack
        add(0,0,0,      1,0,'h44,0,             0,0,           1,0,'h44,0,       0,1,'h11112222,'hABCD,1);
        add(1,0,0,      1,0,'h44,0,             0,0,           0,0,0,0,          0,0,0,0,0);
        add(0,0,0,      0,0,0,0,                1,'h99,        0,0,0,0,          0,0,0,0,0);
        add(0,0,0,      0,0,0,0,                0,0,           0,0,0,0,          0,0,0,0,0);

        for (int i = 0; i < tv.size(); i++) begin
            @(negedge clk);
            drive(tv[i]);
            @(posedge clk);
            #1;
            chk($sformatf("v%0d.mem_req", i), 32'(mreq_o), 32'(tv[i].e_mreq));
            if (tv[i].e_mreq) begin
                chk($sformatf("v%0d.mem_we", i), 32'(mwe_o), 32'(tv[i].e_mwe));
                chk($sformatf("v%0d.mem_addr", i), maddr_o, tv[i].e_maddr);
                chk($sformatf("v%0d.mem_wdata", i), mwdata_o, tv[i].e_mwdata);
            end
            chk($sformatf("v%0d.i_stall", i), 32'(istall_o), 32'(tv[i].e_ist));
            chk($sformatf("v%0d.d_stall", i), 32'(dstall_o), 32'(tv[i].e_dst));
            chk($sformatf("v%0d.i_rdata", i), irdata_o, tv[i].e_ird);
            chk($sformatf("v%0d.d_rdata", i), drdata_o, tv[i].e_drd);
            chk($sformatf("v%0d.err", i), 32'(err_o), 32'(tv[i].e_err));
        end

        // back-to-back: data request raised during I_DONE; stalls are combinational
        @(negedge clk);
        ireq = 1'b1; iaddr = 32'h500; ack = 1'b0;
        #1 chk("seq.i_stall_idle_comb", 32'(istall_o), 32'd1);
        @(negedge clk);
        chk("seq.fetch_busy", 32'(mreq_o), 32'd1);
        ack = 1'b1; rdata = 32'h77;
        #1 chk("seq.i_stall_ack_indep", 32'(istall_o), 32'd1);
        @(negedge clk);
        chk("seq.i_rdata", irdata_o, 32'h77);
        ack = 1'b0; ireq = 1'b0; dreq = 1'b1; dwe = 1'b0; daddr = 32'h600;
        #1 chk("seq.d_stall_in_idone", 32'(dstall_o), 32'd1);
        chk("seq.no_grant_in_done", 32'(mreq_o), 32'd0);
        @(posedge clk); #1;
        chk("seq.idle_no_req", 32'(mreq_o), 32'd0);
        @(posedge clk); #1;
        chk("seq.d_grant", 32'(mreq_o), 32'd1);
        chk("seq.d_addr", maddr_o, 32'h600);
        @(negedge clk);
        ack = 1'b1; rdata = 32'h88;
        #1 chk("seq.d_stall_ack_indep", 32'(dstall_o), 32'd1);
        @(posedge clk); #1;
        chk("seq.d_done_stall", 32'(dstall_o), 32'd0);
        chk("seq.d_rdata", drdata_o, 32'h88);
        @(negedge clk);
        ack = 1'b1; rdata = 32'hBAD; dreq = 1'b0;
        @(posedge clk); #1;
        chk("seq.ack_ignored_done", drdata_o, 32'h88);
        chk("seq.back_idle", 32'(mreq_o), 32'd0);
        @(negedge clk);
        ack = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end

endmodule
